spi_prot_trig: RTL and testbench
================================

// Module: spi_prot_trig
// PURPOSE
//  SPI protocol trigger unit inside LA_dig, directly downstream of channel inputs CH1/CH2/CH3.
//  Snoops an external SPI bus (CH1=SS_n, CH2=SCLK, CH3=MOSI) and shifts in each frame.
//  Pulses SPItrig when a completed frame matches a programmed pattern under a don't-care mask.
//  SPItrig feeds the capture trigger logic as one source alongside channel and UART triggers.
// PARAMETERS
//  MAX_LEN   16   widest frame supported, in bits; shift register and match/mask width
// PORTS
//  clk       in   1   system clock, 100MHz
//  rst_n     in   1   asynchronous active-low reset
//  SS_n      in   1   async SPI slave select (CH1 path); idles high
//  SCLK      in   1   async SPI serial clock (CH2 path); idles high
//  MOSI      in   1   async SPI data (CH3 path)
//  edg       in   1   1: sample MOSI on SCLK rise; 0: sample on SCLK fall
//  len8      in   1   1: 8-bit frame, compare [7:0]; 0: 16-bit frame, compare [15:0]
//  match     in   16  pattern to match; in 8-bit mode only [7:0] is used
//  mask      in   16  per-bit don't-care; 1 = ignore bit; in 8-bit mode only [7:0] is used
//  SPItrig   out  1   one-clk pulse on a matching frame
// BEHAVIOUR
//  - Reset values: SPItrig=0; shift_reg=0; bit_cnt=0; state=IDLE.
//    SS_n and SCLK synchronizer/edge flops reset to 1; MOSI flops reset to 0.
//  - Sync: SS_n, SCLK and MOSI each go through 2 flops, then a 3rd flop.
//    SCLK/SS_n edges are detected from flop 2 vs flop 3.
//    On a selected SCLK edge, MOSI is taken from its flop 3, aligned with the SCLK edge flop.
//  - Inputs are usable only if SCLK high time and low time are each >= 4 clk (SCLK <= clk/8).
//  - FSM, 2 states:
//    IDLE: synced SS_n fall -> RX; clear bit_cnt and shift_reg.
//    RX, selected SCLK edge: shift_reg <= {shift_reg[14:0],MOSI} (MSB first);
//      bit_cnt++, saturating at 17.
//    RX, synced SS_n rise -> IDLE; evaluate the frame in the same cycle.
//    SS_n rise while in IDLE does nothing.
//  - Evaluate: valid = (len8 ? bit_cnt==8 : bit_cnt==16).
//    Match condition: ((shift_reg ^ match) & ~mask) == 0, over the active width only.
//    SPItrig (registered) = valid & match, high for exactly 1 clk.
//  - Latency: SPItrig rises 4 clk after the SS_n pin rises (2 sync + edge + output reg).
//  - Short frame (< len) or long frame (> len, count saturates) -> no trigger.
//    A wrong-length frame never produces a partial or windowed match.
//  - SCLK edge and SS_n rise detected in the same clk: the edge is shifted and counted first;
//    the frame is then evaluated on the updated value.
//  - Edges of the non-selected polarity are ignored.
//  - SCLK edges while in IDLE are ignored.
//  - Changing edg/len8/match/mask mid-frame is illegal; the result is undefined but no lock-up.
//    The FSM always returns to IDLE on the SS_n rise.
//  - rst_n assertion mid-frame: all state clears immediately and no SPItrig is produced.
//    If SS_n is already low at reset release, its fall is detected and a frame is received.
//  - Back-to-back frames (SS_n high for >= 4 clk) each trigger independently.
// TESTING
//  1 edg=0,len8=1,match=16'h0066,mask=0; SPI_mstr sends 8'h66, falling-edge sampling
//    -> one SPItrig pulse, 4 clk after SS_n rise.
//  2 Same setup, master sends 8'h67 -> SPItrig stays 0.
//    Then mask=16'h0001 and resend 8'h67 -> one pulse.
//  3 edg=1,len8=0,match=16'hA5C3,mask=0; send 16'hA5C3 -> one pulse.
//    Send 16'hA5C2 -> none. Send 8'hA5 only (short frame) -> none.
//  4 len8=1; send 24 bits whose first 8 are 8'h66 -> no pulse (bit_cnt saturates).
//    Next 8-bit frame 8'h66 -> one pulse.
//  5 Pull rst_n low after 5 SCLK edges of an 8'h66 frame, release mid-frame
//    -> SPItrig=0 throughout. The next full frame triggers.
//  6 Two matching 8-bit frames, SS_n high for 4 clk between them
//    -> exactly two pulses, each 1 clk wide.

Source files
------------

// File: rtl/spi_prot_trig.sv
// SPI protocol trigger: snoops SS_n/SCLK/MOSI and pulses SPItrig on a
// completed frame matching a programmed pattern under a don't-care mask.
//
// Ports:
//   clk, rst_n      system clock, async active-low reset
//   SS_n,SCLK,MOSI  asynchronous SPI bus inputs (SS_n/SCLK idle high)
//   edg             1: sample MOSI on SCLK rise, 0: on SCLK fall
//   len8            1: 8-bit frame, 0: MAX_LEN-bit frame
//   match, mask     compare pattern and per-bit ignore mask
//   SPItrig         one-clk pulse on a matching, correctly sized frame
module spi_prot_trig #(
  parameter int MAX_LEN = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               SS_n,
  input  logic               SCLK,
  input  logic               MOSI,
  input  logic               edg,
  input  logic               len8,
  input  logic [MAX_LEN-1:0] match,
  input  logic [MAX_LEN-1:0] mask,
  output logic               SPItrig
);

  localparam int CW = $clog2(MAX_LEN + 2);
  localparam logic [CW-1:0] CNT_SAT  = CW'(MAX_LEN + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(MAX_LEN);
  localparam logic [CW-1:0] CNT_BYTE = CW'(8);

  typedef enum logic {
    IDLE = 1'b0,
    RX   = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [2:0] ss_q;
  logic [2:0] sclk_q;
  logic [2:0] mosi_q;

  logic ss_fall_q, ss_rise_q;
  logic sclk_rise_q, sclk_fall_q;

  logic [MAX_LEN-1:0] shift_q, shift_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               trig_q, trig_d;

  logic               samp;
  logic [MAX_LEN-1:0] diff;
  logic               hit;
  logic               valid;

  // Two-flop synchronizers plus a third flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_q   <= 3'b111;
      sclk_q <= 3'b111;
      mosi_q <= 3'b000;
    end else begin
      ss_q   <= {ss_q[1:0], SS_n};
      sclk_q <= {sclk_q[1:0], SCLK};
      mosi_q <= {mosi_q[1:0], MOSI};
    end
  end

  // Registered edge strobes; mosi_q[2] lines up with these.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_fall_q   <= 1'b0;
      ss_rise_q   <= 1'b0;
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
    end else begin
      ss_fall_q   <= ss_q[2] & ~ss_q[1];
      ss_rise_q   <= ~ss_q[2] & ss_q[1];
      sclk_rise_q <= ~sclk_q[2] & sclk_q[1];
      sclk_fall_q <= sclk_q[2] & ~sclk_q[1];
    end
  end

  assign samp = edg ? sclk_rise_q : sclk_fall_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (ss_fall_q) state_d = RX;
      RX:   if (ss_rise_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame datapath; count saturates so long frames never look valid.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      if (ss_fall_q) begin
        shift_d = '0;
        cnt_d   = '0;
      end
    end else if (samp) begin
      shift_d = {shift_q[MAX_LEN-2:0], mosi_q[2]};
      cnt_d   = (cnt_q == CNT_SAT) ? CNT_SAT : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // Evaluate on the updated frame so a coincident last edge is included.
  assign diff  = (shift_d ^ match) & ~mask;
  assign hit   = len8 ? (diff[7:0] == 8'h00) : (diff == '0);
  assign valid = len8 ? (cnt_d == CNT_BYTE) : (cnt_d == CNT_FULL);

  // Output logic
  always_comb begin
    trig_d = 1'b0;
    if (state_q == RX && ss_rise_q) begin
      trig_d = valid & hit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_q <= 1'b0;
    end else begin
      trig_q <= trig_d;
    end
  end

  assign SPItrig = trig_q;

endmodule

// File: tb/tb_spi_prot_trig.sv
// Scoreboard bench for spi_prot_trig: directed SPI frames, expected
// trigger cycles queued by stimulus, checked by a pulse monitor.
module tb_spi_prot_trig;

  localparam int H = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        SS_n, SCLK, MOSI;
  logic        edg, len8;
  logic [15:0] match, mask;
  logic        SPItrig;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int pulses   = 0;
  int exp_q[$];
  int e;

  spi_prot_trig #(.MAX_LEN(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .edg(edg), .len8(len8),
    .match(match), .mask(mask),
    .SPItrig(SPItrig)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (SPItrig === 1'b1) begin
      pulses++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse cyc=%0d expected=none", cyc);
      end else begin
        e = exp_q.pop_front();
        if (cyc != e) begin
          failures++;
          $display("FAIL pulse_time got=%0d want=%0d", cyc, e);
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [23:0] d, input int n, input bit exp,
                      input int rst_bit, input int gap);
    SS_n = 1'b0;
    wait_clk(H);
    for (int i = n - 1; i >= 0; i--) begin
      MOSI = d[i];
      wait_clk(H);
      SCLK = 1'b0;
      wait_clk(H);
      SCLK = 1'b1;
      wait_clk(H);
      if (n - i == rst_bit) begin
        rst_n = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
      end
    end
    SS_n = 1'b1;
    if (exp) exp_q.push_back(cyc + 4);
    wait_clk(gap);
  endtask

  task automatic check_frames(input string name, input int p0, input int want);
    checks++;
    if (pulses - p0 != want) begin
      failures++;
      $display("FAIL %s pulses got=%0d want=%0d", name, pulses - p0, want);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int p;
    rst_n = 1'b0;
    SS_n  = 1'b1;
    SCLK  = 1'b1;
    MOSI  = 1'b0;
    edg   = 1'b0;
    len8  = 1'b1;
    match = 16'h0066;
    mask  = 16'h0000;
    wait_clk(3);
    checks++;
    if (SPItrig !== 1'b0) begin
      failures++;
      $display("FAIL reset_trig got=%b want=0", SPItrig);
    end
    rst_n = 1'b1;
    wait_clk(5);

    p = pulses;
    send(24'h66, 8, 1'b1, -1, 10);
    check_frames("t1_match66", p, 1);

    p = pulses;
    send(24'h67, 8, 1'b0, -1, 10);
    check_frames("t2_nomatch67", p, 0);
    mask = 16'h0001;
    p = pulses;
    send(24'h67, 8, 1'b1, -1, 10);
    check_frames("t2_masked67", p, 1);

    edg   = 1'b1;
    len8  = 1'b0;
    match = 16'hA5C3;
    mask  = 16'h0000;
    p = pulses;
    send(24'hA5C3, 16, 1'b1, -1, 10);
    check_frames("t3_a5c3", p, 1);
    p = pulses;
    send(24'hA5C2, 16, 1'b0, -1, 10);
    check_frames("t3_a5c2", p, 0);
    p = pulses;
    send(24'hA5, 8, 1'b0, -1, 10);
    check_frames("t3_short", p, 0);

    edg   = 1'b0;
    len8  = 1'b1;
    match = 16'h0066;
    p = pulses;
    send(24'h66A5C3, 24, 1'b0, -1, 10);
    check_frames("t4_long", p, 0);
    p = pulses;
    send(24'h66, 8, 1'b1, -1, 10);
    check_frames("t4_after_long", p, 1);

    p = pulses;
    send(24'h66, 8, 1'b0, 5, 10);
    check_frames("t5_reset_mid", p, 0);
    p = pulses;
    send(24'h66, 8, 1'b1, -1, 10);
    check_frames("t5_after_reset", p, 1);

    p = pulses;
    send(24'h66, 8, 1'b1, -1, 4);
    send(24'h66, 8, 1'b1, -1, 10);
    check_frames("t6_back_to_back", p, 2);

    wait_clk(10);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_pulses got=%0d want=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
